lfsr_prng_multi: RTL and testbench
==================================

Name: lfsr_prng_multi

Overview:
- Parametrised, multi-channel Galois LFSR pseudo-random generator. It is the successor to the fixed dual-output (10-bit address / 32-bit data) LFSR.
- Each channel has an independent state register, enable, seed load and wrap detection.
- Two advance modes: free-run (step every enabled cycle) and handshake (step only on valid & ready).
- Feeds PRN address/data streams to memory-test and traffic-generator blocks.

Parameters:
- WIDTH, 32: LFSR state width in bits (>= 3).
- NUM_CH, 2: number of independent channels (>= 1).
- TAPS, 32'h80200003: Galois feedback mask (right-shift form; default is x^32+x^22+x^2+x+1).
- DEFAULT_SEED, 1: reset state and zero-seed substitute. Must be nonzero; elaboration fails otherwise.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = free-run, 1 = handshake; global, sampled every cycle
- en  in  NUM_CH  per-channel enable
- load  in  1  seed-load strobe
- load_ch  in  $clog2(NUM_CH) (min 1)  target channel for load
- load_seed  in  WIDTH  seed value
- out_ready  in  NUM_CH  consumer ready (used in handshake mode only)
- out_valid  out  NUM_CH  channel output valid
- out_data  out  NUM_CH*WIDTH  packed channel states; channel c at [c*WIDTH +: WIDTH]
- wrap  out  NUM_CH  one-cycle pulse: channel state has returned to its seed

Behaviour:
- Reset (rst=0, asynchronous):
  - every state = DEFAULT_SEED, every seed_reg = DEFAULT_SEED
  - wrap = 0
  - out_valid = 0 (follows from en gating, since en is expected low in reset)
- Step function: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- out_data[c] is the state register itself: zero latency from state to output.
- out_valid[c] = en[c] (combinational), in both modes.
- Advance condition per channel:
  - mode 0: adv[c] = en[c]
  - mode 1: adv[c] = en[c] & out_ready[c]
- Load, on the cycle load=1 for channel k = load_ch:
  - state[k] and seed_reg[k] take load_seed next edge.
  - load beats advance on the same channel in the same cycle; other channels advance normally.
  - load_seed == 0 is replaced by DEFAULT_SEED, because the all-zero state is a lockup.
  - load_ch >= NUM_CH: the load is ignored.
- Wrap detection:
  - wrap[c] is registered. It is 1 in the cycle after an advance whose next value equals seed_reg[c]; otherwise 0.
  - A load never raises wrap.
  - Simultaneous wraps on several channels are independent.
- Lockup guard: if state is ever 0, the next edge forces it to DEFAULT_SEED regardless of en. This does not occur in normal operation and is covered by an assertion.
- Handshake in mode 1: out_data is held stable while out_valid & !out_ready. Data changes only after a valid&ready transfer or a load.
- Mode switch mid-stream: takes effect the same cycle with no state disturbance.
- Reset asserted mid-operation: immediate asynchronous return to the reset values above. Seeds loaded earlier are lost.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_step(state, taps)
  - localparam CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
  - common polynomial constants: POLY32 = 32'h80200003, POLY10 = 10'h240, POLY4 = 4'hC
- Sub-module lfsr_chan holds the state, seed_reg, load, wrap and lockup logic for one channel.
- Top instantiates NUM_CH copies of lfsr_chan in a generate loop and does the load_ch decode and mode/advance muxing.

Test Plan (WIDTH=4, TAPS=4'hC, DEFAULT_SEED=1, NUM_CH=2 unless noted):
1. Reset release, then en=2'b01, mode 0 → ch0 out_data = 1, C, 6, 3, D, A, 5, E, 7, F, B, 9, 8, 4, 2, 1. wrap[0] pulses exactly when state returns to 1 (the 15th step). ch1 is held at 1 with wrap[1]=0.
2. Load ch1 seed 4'hA, en=2'b10 → ch1 = A, 5, E, 7, ... and wrap[1] pulses after 15 steps, when state returns to A. There is no wrap on the load cycle.
3. load_seed=0 to ch0 → ch0 state = 1 next cycle, with no lockup. A load to load_ch=3 (NUM_CH=2) → no state change on any channel.
4. Mode 1, en=2'b11, out_ready toggling 1,0,0,1 on ch0 → ch0 advances only on ready cycles (1→C held held→6). ch1 with ready=0 stays at its value with out_valid=1.
5. load and adv on the same channel in the same cycle → loaded seed wins. The other channel advances one step in that cycle.
6. WIDTH=32 default taps, seed 1, 1000 steps → matches reference-model lfsr_step values. Assert rst low mid-run → out_data = 1 and wrap = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the multi-channel Galois LFSR generator.
package lfsr_pkg;

   // Widest state the step helper supports; callers zero-extend into it.
   localparam int unsigned MAX_W = 64;

   // Common feedback masks, right-shift Galois form.
   localparam logic [31:0] POLY32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1
   localparam logic [9:0]  POLY10 = 10'h240;
   localparam logic [3:0]  POLY4  = 4'hC;

   // Channel-select width; at least one bit even for a single channel.
   function automatic int unsigned calc_ch_w(input int unsigned num_ch);
      if (num_ch > 32'd1) return unsigned'($clog2(num_ch));
      return 32'd1;
   endfunction

   // One Galois step. Zero-extended upper bits stay zero, so truncating
   // the result back to the caller's width gives the exact narrow step.
   function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps);
      return (state >> 1) ^ (state[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One LFSR channel: state, seed register, load, wrap pulse and lockup guard.
module lfsr_chan
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(POLY32),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             load,
   input  logic [WIDTH-1:0] load_seed,
   output logic [WIDTH-1:0] state,
   output logic             wrap
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] step_nxt;

   // Next Galois value of the current state.
   always_comb step_nxt = WIDTH'(lfsr_step(MAX_W'(state_q), MAX_W'(TAPS)));

   // Load beats lockup recovery beats advance; only an advance can wrap.
   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      wrap_d  = 1'b0;
      if (load) begin
         seed_d  = (load_seed == '0) ? DEFAULT_SEED : load_seed;
         state_d = seed_d;
      end else if (state_q == '0) begin
         state_d = DEFAULT_SEED;
      end else if (adv) begin
         state_d = step_nxt;
         wrap_d  = (step_nxt == seed_q);
      end
   end

   // State, seed and wrap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DEFAULT_SEED;
         seed_q  <= DEFAULT_SEED;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         wrap_q  <= wrap_d;
      end
   end

   assign state = state_q;
   assign wrap  = wrap_q;

   // The all-zero state is unreachable from a nonzero seed.
   a_no_lockup: assert property (@(posedge clk) disable iff (!rst_n) state_q != '0)
      else $error("lfsr_chan: all-zero lockup state");

endmodule

// File: rtl/lfsr_prng_multi.sv
// Multi-channel Galois LFSR PRNG with free-run and valid/ready advance modes.
module lfsr_prng_multi
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      NUM_CH       = 2,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(POLY32),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
   localparam int unsigned     CH_W         = calc_ch_w(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    load,
   input  logic [CH_W-1:0]         load_ch,
   input  logic [WIDTH-1:0]        load_seed,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [NUM_CH-1:0]       out_valid,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]       wrap
);

   // Reject configurations that cannot produce a valid sequence.
   if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("lfsr_prng_multi: DEFAULT_SEED must be nonzero");
   end
   if ((WIDTH < 3) || (WIDTH > MAX_W)) begin : g_bad_width
      $error("lfsr_prng_multi: WIDTH out of supported range");
   end
   if (NUM_CH < 1) begin : g_bad_ch
      $error("lfsr_prng_multi: NUM_CH must be at least 1");
   end

   logic [NUM_CH-1:0] adv_c;
   logic [NUM_CH-1:0] ld_c;

   // Valid follows enable directly in both modes.
   assign out_valid = en;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // Handshake mode only steps on a completed transfer.
      assign adv_c[c] = en[c] & (~mode | out_ready[c]);
      // Out-of-range channel numbers match no channel and are dropped.
      assign ld_c[c]  = load & (load_ch == CH_W'(c));

      lfsr_chan #(
         .WIDTH        (WIDTH),
         .TAPS         (TAPS),
         .DEFAULT_SEED (DEFAULT_SEED)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst),
         .adv       (adv_c[c]),
         .load      (ld_c[c]),
         .load_seed (load_seed),
         .state     (out_data[c*WIDTH +: WIDTH]),
         .wrap      (wrap[c])
      );
   end

endmodule

// File: tb/tb_lfsr_prng_multi.sv
// Scoreboard bench for lfsr_prng_multi: 4-bit three-channel and 32-bit one-channel builds.
module tb_lfsr_prng_multi;

   localparam int unsigned W  = 4;
   localparam int unsigned NC = 3;
   localparam int unsigned CW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            mode;
   logic [NC-1:0]   en, out_ready, out_valid, wrap;
   logic            load;
   logic [CW-1:0]   load_ch;
   logic [W-1:0]    load_seed;
   logic [NC*W-1:0] out_data;

   logic        en32, rdy32, valid32, wrap32, load32, load_ch32;
   logic [31:0] seed32, data32;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic [NC*W-1:0] data;
      logic [NC-1:0]   wrap;
   } exp_t;

   exp_t       sb[$];
   logic [W-1:0] m_state[NC];
   logic [W-1:0] m_seed[NC];

   lfsr_prng_multi #(.WIDTH(4), .NUM_CH(3), .TAPS(4'hC), .DEFAULT_SEED(4'h1)) dut4 (
      .clk(clk), .rst(rst), .mode(mode), .en(en), .load(load), .load_ch(load_ch),
      .load_seed(load_seed), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .wrap(wrap));

   lfsr_prng_multi #(.NUM_CH(1)) dut32 (
      .clk(clk), .rst(rst), .mode(1'b0), .en(en32), .load(load32), .load_ch(load_ch32),
      .load_seed(seed32), .out_ready(rdy32), .out_valid(valid32),
      .out_data(data32), .wrap(wrap32));

   function automatic logic [3:0] step4(input logic [3:0] s);
      return (s >> 1) ^ (s[0] ? 4'hC : 4'h0);
   endfunction

   function automatic logic [31:0] step32(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Model the coming edge from the inputs now driven and queue the result.
   task automatic push_expected();
      exp_t e;
      logic adv;
      for (int c = 0; c < NC; c++) begin
         adv = en[c] && (!mode || out_ready[c]);
         e.wrap[c] = 1'b0;
         if (load && (int'(load_ch) == c)) begin
            m_seed[c]  = (load_seed == 4'h0) ? 4'h1 : load_seed;
            m_state[c] = m_seed[c];
         end else if (adv) begin
            m_state[c] = step4(m_state[c]);
            e.wrap[c]  = (m_state[c] == m_seed[c]);
         end
         e.data[c*W +: W] = m_state[c];
      end
      sb.push_back(e);
   endtask

   // Check valid, clock once, then pop and compare the scoreboard entry.
   task automatic clock_check(input string name);
      exp_t e;
      push_expected();
      #1;
      vectors++;
      if (out_valid !== en) begin
         errors++;
         $display("FAIL %s valid: out_valid=%b expected %b", name, out_valid, en);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         if (out_data !== e.data || wrap !== e.wrap) begin
            errors++;
            $display("FAIL %s: out_data=%h wrap=%b expected out_data=%h wrap=%b",
                     name, out_data, wrap, e.data, e.wrap);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; mode = 1'b0; en = '0; out_ready = '0; load = 1'b0; load_ch = '0; load_seed = '0;
      en32 = 1'b0; rdy32 = 1'b0; load32 = 1'b0; load_ch32 = 1'b0; seed32 = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_data !== {NC{4'h1}} || wrap !== '0 || out_valid !== '0) begin
         errors++;
         $display("FAIL reset4: out_data=%h wrap=%b valid=%b expected %h 0 0",
                  out_data, wrap, out_valid, {NC{4'h1}});
      end
      vectors++;
      if (data32 !== 32'h1 || wrap32 !== 1'b0) begin
         errors++;
         $display("FAIL reset32: out_data=%h wrap=%b expected 1 0", data32, wrap32);
      end
      for (int c = 0; c < NC; c++) begin
         m_state[c] = 4'h1;
         m_seed[c]  = 4'h1;
      end
      rst = 1'b1;
   endtask

   task automatic test_free_run();
      logic [3:0] seq[16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                              4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
      en = 3'b001;
      for (int i = 1; i < 16; i++) begin
         clock_check("free_run");
         vectors++;
         if (out_data[3:0] !== seq[i] || wrap[0] !== (i == 15) || out_data[7:4] !== 4'h1 || wrap[1] !== 1'b0) begin
            errors++;
            $display("FAIL free_run_seq step %0d: ch0=%h wrap=%b ch1=%h expected ch0=%h wrap0=%b ch1=1",
                     i, out_data[3:0], wrap, out_data[7:4], seq[i], (i == 15));
         end
      end
   endtask

   task automatic test_load_wrap();
      en = 3'b000; load = 1'b1; load_ch = 2'd1; load_seed = 4'hA;
      clock_check("load_ch1");
      load = 1'b0; en = 3'b010;
      for (int i = 1; i <= 15; i++) clock_check("ch1_wrap");
      vectors++;
      if (out_data[7:4] !== 4'hA || wrap[1] !== 1'b1) begin
         errors++;
         $display("FAIL ch1_wrap_end: ch1=%h wrap1=%b expected A 1", out_data[7:4], wrap[1]);
      end
      en = 3'b000;
   endtask

   task automatic test_load_zero_and_bad_ch();
      load = 1'b1; load_ch = 2'd0; load_seed = 4'h0;
      clock_check("load_zero");
      load_ch = 2'd3; load_seed = 4'h5;
      clock_check("load_bad_ch");
      load = 1'b0;
      clock_check("idle");
   endtask

   task automatic test_handshake();
      logic [3:0] rdy[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0] exp0[4] = '{4'hC, 4'hC, 4'hC, 4'h6};
      load = 1'b1; load_ch = 2'd0; load_seed = 4'h1;
      clock_check("hs_seed");
      load = 1'b0; mode = 1'b1; en = 3'b011;
      for (int i = 0; i < 4; i++) begin
         out_ready = {2'b00, rdy[i][0]};
         clock_check("handshake");
         vectors++;
         if (out_data[3:0] !== exp0[i] || out_data[7:4] !== 4'hA) begin
            errors++;
            $display("FAIL handshake_hold %0d: ch0=%h ch1=%h expected ch0=%h ch1=A",
                     i, out_data[3:0], out_data[7:4], exp0[i]);
         end
      end
      out_ready = '0;
   endtask

   task automatic test_back_to_back();
      mode = 1'b0; en = 3'b011; load = 1'b1; load_ch = 2'd0; load_seed = 4'h7;
      clock_check("load_vs_adv");
      vectors++;
      if (out_data[3:0] !== 4'h7 || out_data[7:4] !== 4'h5) begin
         errors++;
         $display("FAIL load_vs_adv_direct: ch0=%h ch1=%h expected 7 5", out_data[3:0], out_data[7:4]);
      end
      load = 1'b0;
      clock_check("after_load");
      en = '0;
   endtask

   task automatic test_width32_and_async_reset();
      logic [31:0] m;
      m = 32'h1;
      en32 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         m = step32(m);
         vectors++;
         if (data32 !== m || wrap32 !== 1'b0 || valid32 !== 1'b1) begin
            errors++;
            $display("FAIL w32 step %0d: out_data=%h wrap=%b expected %h 0", i, data32, wrap32, m);
         end
      end
      en32 = 1'b0;
      // Bring ch0 up to a wrap pulse so the reset has something to clear.
      load = 1'b1; load_ch = 2'd0; load_seed = 4'h4;
      clock_check("pre_reset_load");
      load = 1'b0; en = 3'b001;
      for (int i = 0; i < 15; i++) clock_check("pre_reset_run");
      en = '0;
      vectors++;
      if (wrap[0] !== 1'b1 || data32 !== m) begin
         errors++;
         $display("FAIL pre_reset: wrap=%b out_data32=%h expected wrap0=1 %h", wrap, data32, m);
      end
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if (out_data !== {NC{4'h1}} || wrap !== '0 || data32 !== 32'h1 || wrap32 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out_data=%h wrap=%b out_data32=%h wrap32=%b expected %h 0 1 0",
                  out_data, wrap, data32, wrap32, {NC{4'h1}});
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_load_wrap();
      test_load_zero_and_bad_ch();
      test_handshake();
      test_back_to_back();
      test_width32_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
